// File: rtl/gpu_ctrl_regs.sv
// AXI4-lite register file and frame sequencer for gpu_top: holds triangle count and base
// addresses, launches a frame on START and reports completion through DONE/irq.
module gpu_ctrl_regs #(
    parameter int unsigned SADDR_WIDTH = 32,
    parameter int unsigned MADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [SADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [SADDR_WIDTH-1:0] araddr,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [31:0]            rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic                   frame_end,
    output logic                   frame_start,
    output logic [31:0]            triangles_count,
    output logic [MADDR_WIDTH-1:0] base_addr_vertex,
    output logic [MADDR_WIDTH-1:0] base_addr_color,
    output logic                   irq
);

    localparam logic W_IDLE = 1'b0;
    localparam logic W_RESP = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_TRI    = 3'd2;
    localparam logic [2:0] A_VTX    = 3'd3;
    localparam logic [2:0] A_COL    = 3'd4;
    localparam logic [2:0] A_FCNT   = 3'd5;

    logic        wstate_q, wstate_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [2:0]  waddr_q, waddr_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        rstate_q, rstate_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        irq_en_q, irq_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] tri_cnt_q, tri_cnt_d;
    logic [31:0] vtx_base_q, vtx_base_d;
    logic [31:0] col_base_q, col_base_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        frame_start_q, frame_start_d;

    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, awaddr[SADDR_WIDTH-1:5], awaddr[1:0],
                             araddr[SADDR_WIDTH-1:5], araddr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

    // Write channel, register commit and frame sequencing.
    always_comb begin
        wstate_d      = wstate_q;
        awready_d     = awready_q;
        wready_d      = wready_q;
        aw_got_d      = aw_got_q;
        w_got_d       = w_got_q;
        waddr_d       = waddr_q;
        wbuf_d        = wbuf_q;
        wstrb_d       = wstrb_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        irq_en_d      = irq_en_q;
        busy_d        = busy_q;
        done_d        = done_q;
        tri_cnt_d     = tri_cnt_q;
        vtx_base_d    = vtx_base_q;
        col_base_d    = col_base_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;

        unique case (wstate_q)
            W_IDLE: begin
                if (aw_got_q && w_got_q) begin
                    bresp_d  = RESP_OKAY;
                    case (waddr_q)
                        A_CTRL: begin
                            if (busy_q) begin
                                // START while busy is a harmless retrigger; IRQ_EN change is refused
                                if (!(wstrb_q[0] && wbuf_q[0])) bresp_d = RESP_SLVERR;
                            end else if (wstrb_q[0]) begin
                                irq_en_d = wbuf_q[1];
                                if (wbuf_q[0]) begin
                                    if (tri_cnt_q != 32'd0) begin
                                        frame_start_d = 1'b1;
                                        busy_d        = 1'b1;
                                    end else begin
                                        done_d      = 1'b1;
                                        frame_cnt_d = frame_cnt_q + 32'd1;
                                    end
                                end
                            end
                        end
                        A_STATUS: begin
                            if (wstrb_q[0] && wbuf_q[1]) done_d = 1'b0;
                        end
                        A_TRI: begin
                            if (busy_q) bresp_d = RESP_SLVERR;
                            else tri_cnt_d = merge_bytes(tri_cnt_q, wbuf_q, wstrb_q);
                        end
                        A_VTX: begin
                            if (busy_q) bresp_d = RESP_SLVERR;
                            else vtx_base_d = merge_bytes(vtx_base_q, wbuf_q, wstrb_q);
                        end
                        A_COL: begin
                            if (busy_q) bresp_d = RESP_SLVERR;
                            else col_base_d = merge_bytes(col_base_q, wbuf_q, wstrb_q);
                        end
                        A_FCNT: ;
                        default: bresp_d = RESP_SLVERR;
                    endcase
                    bvalid_d  = 1'b1;
                    wstate_d  = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    if (awvalid && awready_q) begin
                        aw_got_d = 1'b1;
                        waddr_d  = awaddr[4:2];
                    end
                    if (wvalid && wready_q) begin
                        w_got_d = 1'b1;
                        wbuf_d  = wdata;
                        wstrb_d = wstrb;
                    end
                    awready_d = !aw_got_d;
                    wready_d  = !w_got_d;
                end
            end
            W_RESP: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (bready) begin
                    bvalid_d  = 1'b0;
                    wstate_d  = W_IDLE;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase

        // Evaluated after the commit so a completion beats a same-cycle DONE clear.
        if (frame_end && busy_q) begin
            busy_d      = 1'b0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    // Read channel; data comes from current register state, so a same-cycle commit is not seen.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        unique case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rresp_d = RESP_OKAY;
                    case (araddr[4:2])
                        A_CTRL:   rdata_d = {30'd0, irq_en_q, 1'b0};
                        A_STATUS: rdata_d = {30'd0, done_q, busy_q};
                        A_TRI:    rdata_d = tri_cnt_q;
                        A_VTX:    rdata_d = vtx_base_q;
                        A_COL:    rdata_d = col_base_q;
                        A_FCNT:   rdata_d = frame_cnt_q;
                        default: begin
                            rdata_d = 32'd0;
                            rresp_d = RESP_SLVERR;
                        end
                    endcase
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                arready_d = 1'b0;
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q      <= W_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            aw_got_q      <= 1'b0;
            w_got_q       <= 1'b0;
            waddr_q       <= 3'd0;
            wbuf_q        <= 32'd0;
            wstrb_q       <= 4'd0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'd0;
            rstate_q      <= R_IDLE;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
            rresp_q       <= 2'd0;
            irq_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tri_cnt_q     <= 32'd0;
            vtx_base_q    <= 32'd0;
            col_base_q    <= 32'd0;
            frame_cnt_q   <= 32'd0;
            frame_start_q <= 1'b0;
        end else begin
            wstate_q      <= wstate_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            aw_got_q      <= aw_got_d;
            w_got_q       <= w_got_d;
            waddr_q       <= waddr_d;
            wbuf_q        <= wbuf_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            rstate_q      <= rstate_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            irq_en_q      <= irq_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tri_cnt_q     <= tri_cnt_d;
            vtx_base_q    <= vtx_base_d;
            col_base_q    <= col_base_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign awready          = awready_q;
    assign wready           = wready_q;
    assign bvalid           = bvalid_q;
    assign bresp            = bresp_q;
    assign arready          = arready_q;
    assign rvalid           = rvalid_q;
    assign rdata            = rdata_q;
    assign rresp            = rresp_q;
    assign frame_start      = frame_start_q;
    assign triangles_count  = tri_cnt_q;
    assign base_addr_vertex = vtx_base_q[MADDR_WIDTH-1:0];
    assign base_addr_color  = col_base_q[MADDR_WIDTH-1:0];
    assign irq              = done_q & irq_en_q;

endmodule

// File: tb/tb_gpu_ctrl_regs.sv
// Scoreboard bench for gpu_ctrl_regs: expected B/R responses are queued as each transfer is
// issued and checked when the DUT returns them.
module tb_gpu_ctrl_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        frame_end, frame_start, irq;
    logic [31:0] triangles_count, base_addr_vertex, base_addr_color;

    int n_checks = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;

    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_start) fs_cnt++;

    gpu_ctrl_regs #(.SADDR_WIDTH(32), .MADDR_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .frame_end(frame_end), .frame_start(frame_start),
        .triangles_count(triangles_count), .base_addr_vertex(base_addr_vertex),
        .base_addr_color(base_addr_color), .irq(irq)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit aw_first,
                             input logic [1:0] exp_resp, input int hold, input bit fe_at_commit);
        bit aw_done, w_done, aw_f, w_f;
        logic [1:0] exp;
        int n;
        exp_b_q.push_back(exp_resp);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = !aw_first;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge clk);
            n++;
            if (aw_f) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_f)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            if (aw_first && n == 1 && !w_done) wvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_eq({tag, "_hs"}, {63'd0, aw_done && w_done}, 64'd1);
        if (fe_at_commit) begin
            frame_end = 1'b1;
            @(negedge clk);
            frame_end = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check_eq({tag, "_bvalid"}, {63'd0, bvalid}, 64'd1);
        exp = exp_b_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_bvalid_hold"}, {63'd0, bvalid}, 64'd1);
            check_eq({tag, "_bresp_hold"}, {62'd0, bresp}, {62'd0, exp});
        end
        check_eq({tag, "_bresp"}, {62'd0, bresp}, {62'd0, exp});
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        logic [33:0] exp;
        int n;
        exp_r_q.push_back({exp_resp, exp_data});
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check_eq({tag, "_arready"}, {63'd0, arready}, 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check_eq({tag, "_rvalid"}, {63'd0, rvalid}, 64'd1);
        exp = exp_r_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_rvalid_hold"}, {63'd0, rvalid}, 64'd1);
            check_eq({tag, "_rdata_hold"}, {32'd0, rdata}, {32'd0, exp[31:0]});
        end
        check_eq({tag, "_rresp"}, {62'd0, rresp}, {62'd0, exp[33:32]});
        check_eq({tag, "_rdata"}, {32'd0, rdata}, {32'd0, exp[31:0]});
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        frame_end = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {61'd0, awready, wready, arready}, 64'd0);
        check_eq("rst_valid", {62'd0, bvalid, rvalid}, 64'd0);
        check_eq("rst_outs", {62'd0, frame_start, irq}, 64'd0);
        check_eq("rst_tri", {32'd0, triangles_count}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", {61'd0, awready, wready, arready}, 64'd7);

        axi_write("wr_tri", 32'h08, 32'd5, 4'hF, 1'b1, OKAY, 0, 1'b0);
        axi_write("wr_vtx", 32'h0C, 32'h1000, 4'hF, 1'b1, OKAY, 0, 1'b0);
        axi_write("wr_col", 32'h10, 32'h2000, 4'hF, 1'b1, OKAY, 0, 1'b0);
        check_eq("out_tri", {32'd0, triangles_count}, 64'd5);
        check_eq("out_vtx", {32'd0, base_addr_vertex}, 64'h1000);
        check_eq("out_col", {32'd0, base_addr_color}, 64'h2000);

        axi_write("wr_vtx_strb", 32'h0C, 32'hFFFF_FFAA, 4'b0010, 1'b0, OKAY, 0, 1'b0);
        check_eq("out_vtx_strb", {32'd0, base_addr_vertex}, 64'hFF00);
        axi_write("wr_vtx_back", 32'h0C, 32'h1000, 4'hF, 1'b0, OKAY, 0, 1'b0);

        // Frame 1
        axi_write("wr_start1", 32'h00, 32'h3, 4'hF, 1'b0, OKAY, 0, 1'b0);
        check_eq("fs_cnt1", fs_cnt, 64'd1);
        axi_read("rd_status_busy", 32'h04, 32'h1, OKAY, 0);
        axi_read("rd_ctrl", 32'h00, 32'h2, OKAY, 0);
        axi_write("wr_tri_busy", 32'h08, 32'd9, 4'hF, 1'b0, SLVERR, 0, 1'b0);
        axi_read("rd_tri_busy", 32'h08, 32'd5, OKAY, 0);
        axi_write("wr_start_busy", 32'h00, 32'h3, 4'hF, 1'b0, OKAY, 0, 1'b0);
        check_eq("fs_cnt_busy", fs_cnt, 64'd1);
        pulse_frame_end();
        check_eq("irq_done1", {63'd0, irq}, 64'd1);
        axi_read("rd_status_done", 32'h04, 32'h2, OKAY, 0);
        axi_read("rd_fcnt1", 32'h14, 32'd1, OKAY, 0);

        // Frame 2: W1C lands on the same edge as frame_end
        axi_write("wr_start2", 32'h00, 32'h3, 4'hF, 1'b0, OKAY, 0, 1'b0);
        check_eq("fs_cnt2", fs_cnt, 64'd2);
        axi_read("rd_status_db", 32'h04, 32'h3, OKAY, 0);
        axi_write("wr_w1c_fe", 32'h04, 32'h2, 4'hF, 1'b0, OKAY, 0, 1'b1);
        axi_read("rd_status_set_wins", 32'h04, 32'h2, OKAY, 0);
        check_eq("irq_set_wins", {63'd0, irq}, 64'd1);
        axi_read("rd_fcnt2", 32'h14, 32'd2, OKAY, 0);
        axi_write("wr_w1c", 32'h04, 32'h2, 4'hF, 1'b0, OKAY, 0, 1'b0);
        axi_read("rd_status_clr", 32'h04, 32'h0, OKAY, 0);
        check_eq("irq_clr", {63'd0, irq}, 64'd0);
        pulse_frame_end();
        axi_read("rd_status_idle_fe", 32'h04, 32'h0, OKAY, 0);
        axi_read("rd_fcnt_idle_fe", 32'h14, 32'd2, OKAY, 0);

        // Zero-triangle frame completes without a pipeline pass
        axi_write("wr_tri0", 32'h08, 32'd0, 4'hF, 1'b0, OKAY, 0, 1'b0);
        axi_write("wr_start0", 32'h00, 32'h1, 4'hF, 1'b0, OKAY, 0, 1'b0);
        check_eq("fs_cnt_tri0", fs_cnt, 64'd2);
        check_eq("irq_en_off", {63'd0, irq}, 64'd0);
        axi_read("rd_status_tri0", 32'h04, 32'h2, OKAY, 0);
        axi_read("rd_fcnt3", 32'h14, 32'd3, OKAY, 0);
        axi_read("rd_bad", 32'h18, 32'd0, SLVERR, 0);
        axi_write("wr_bad", 32'h1C, 32'hDEAD, 4'hF, 1'b0, SLVERR, 0, 1'b0);

        // Backpressure on both response channels
        axi_write("wr_hold", 32'h08, 32'd3, 4'hF, 1'b0, OKAY, 10, 1'b0);
        axi_read("rd_hold", 32'h08, 32'd3, OKAY, 10);

        // Reset pulse after the write handshake but before its commit
        awaddr = 32'h08; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("abort_ready", {61'd0, awready, wready, arready}, 64'd0);
        check_eq("abort_bvalid", {63'd0, bvalid}, 64'd0);
        check_eq("abort_tri", {32'd0, triangles_count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_abort_bvalid", {63'd0, bvalid}, 64'd0);
        end
        check_eq("post_abort_tri", {32'd0, triangles_count}, 64'd0);
        check_eq("post_abort_ready", {61'd0, awready, wready, arready}, 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
